uart_rx: RTL and testbench

Serial UART receiver for the `uart_rx` pin of `top`. It pairs with the existing transmit path on `uart_tx`, and runs in the single `clk` domain (50 MHz on the board). It synchronizes the asynchronous line, detects and validates start bits, and samples 8N1 frames, LSB first, at mid-bit. Each received byte is presented on a one-entry valid/ready output holding register, with framing-error and overrun reporting.

---
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a two-flop input synchronizer, mid-bit
// sampling, framing-error detection and a one-entry valid/ready holding
// register with overrun reporting. Single clock domain.
module uart_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  // Derived timing; CPB must be at least 4 for the half-bit start check to work.
  localparam int CPB   = CLK_HZ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CPB_M1  = CNT_W'(CPB - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic             rx_meta_q, rx_s_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             done_q, done_d;
  logic             stop_ok_q, stop_ok_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  // Two-flop synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM: start validation at half bit, then one sample per bit period.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    stop_ok_d = stop_ok_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          // A line that is already high again was only a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CPB_M1) begin
          cnt_d     = '0;
          done_d    = 1'b1;
          stop_ok_d = rx_s_q;
          // Back in IDLE mid-stop-bit so a zero-gap next start is caught.
          state_d   = rx_s_q ? S_IDLE : S_BREAK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        // A held-low line must go high before another start is accepted.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, counters and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      done_q    <= 1'b0;
      stop_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      stop_ok_q <= stop_ok_d;
    end
  end

  // Holding register: deliver completed bytes, consume on handshake, flag drops.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = done_q && !stop_ok_q;
    ovr_d   = 1'b0;
    if (done_q && stop_ok_q) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a transaction-level
// reference model; every output is compared on every cycle.
module tb_uart_rx;

  localparam int CPB = 10;
  // Output appears 99 edges after the edge preceding the falling start edge:
  // 2 synchronizer edges + 1 detect edge (T0) + 96.
  localparam int LAT = 99;

  logic       clk = 1'b0;
  logic       rst, rx, ready;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  uart_rx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;
  int         q_due[$];
  logic [7:0] q_byte[$];
  bit         q_good[$];
  bit         rnd_ready = 1'b0;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  // Advance the model by the edge that just happened (inputs as seen at that edge).
  task automatic model_step();
    logic [7:0] b;
    bit g;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      q_due.delete();
      q_byte.delete();
      q_good.delete();
    end else if (q_due.size() > 0 && q_due[0] == cyc) begin
      void'(q_due.pop_front());
      b = q_byte.pop_front();
      g = q_good.pop_front();
      if (g) begin
        if (!m_valid || ready) begin
          m_data  = b;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else begin
        m_ferr = 1'b1;
        if (m_valid && ready) m_valid = 1'b0;
      end
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_step();
    check("data", data, m_data);
    check("valid", 8'(valid), 8'(m_valid));
    check("frame_err", 8'(frame_err), 8'(m_ferr));
    check("overrun", 8'(overrun), 8'(m_ovr));
    if (rnd_ready) ready = ($urandom_range(0, 3) == 0);
  endtask

  // Drive one full 8N1 frame and register its expected outcome.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    q_due.push_back(cyc + LAT);
    q_byte.push_back(b);
    q_good.push_back(stop);
    for (int k = 0; k < 10; k++) begin
      rx = bits[k];
      repeat (CPB) tick();
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         gap;
    rst = 1'b1; rx = 1'b1; ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();

    // 0xA5 held until a single-cycle ready
    send_frame(8'hA5, 1'b1);
    repeat (3) tick();
    ready = 1'b1; tick();
    ready = 1'b0; repeat (3) tick();

    // Back-to-back 0x00 then 0xFF with ready high
    ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (5) tick();

    // Three-cycle start glitch, then a real frame to show the FSM is idle
    rx = 1'b0; repeat (3) tick();
    rx = 1'b1; repeat (20) tick();
    send_frame(8'h81, 1'b1);
    repeat (3) tick();

    // Framing error followed by a held-low line, then recovery
    send_frame(8'h3C, 1'b0);
    rx = 1'b0; repeat (50) tick();
    rx = 1'b1; repeat (5) tick();
    send_frame(8'h5A, 1'b1);
    repeat (3) tick();

    // Overrun: two bytes with ready low
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (3) tick();
    ready = 1'b1; tick();
    ready = 1'b0; repeat (3) tick();

    // Reset during bit 4 of 0x96 while a byte is held, then receive 0xC3
    send_frame(8'hE7, 1'b1);
    rx = 1'b0; repeat (CPB) tick();
    for (int k = 0; k < 4; k++) begin
      rx = rb_bit(8'h96, k);
      repeat (CPB) tick();
    end
    rx = 1'b1; repeat (5) tick();
    rst = 1'b1; tick();
    rst = 1'b0; repeat (30) tick();
    send_frame(8'hC3, 1'b1);
    repeat (3) tick();
    ready = 1'b1; tick();
    ready = 1'b0; repeat (3) tick();

    // Randomized frames, gaps, stop bits and ready
    rnd_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      gap = $urandom_range(0, 4);
      rx = 1'b1;
      repeat (gap) tick();
      rb = 8'($urandom);
      rs = ($urandom_range(0, 5) != 0);
      send_frame(rb, rs);
      if (!rs) begin
        rx = 1'b1;
        repeat (3) tick();
      end
    end
    rx = 1'b1;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic rb_bit(input logic [7:0] b, input int k);
    return b[k];
  endfunction

endmodule
